core_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the NPC core.
- Fetches each instruction over a valid/ready instruction-memory port and holds it stable while the combinational IDU/EXU evaluate.
- Issues the EXU's load/store over a data-memory port and produces single-cycle commit strobes for GPR write and PC update.
- Sits between the memory interfaces and the IDU/EXU datapath; converts the single-cycle datapath into a handshaked multi-cycle one.

---
 rtl/core_seq_ctrl_pkg.sv | 42 ++++
 rtl/core_seq_ctrl_mem_wait_timer.sv | 30 +++
 rtl/core_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// core_seq_ctrl shared types: FSM encoding,
// error cause codes and reset defaults.
package core_seq_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          TIMEOUT_DEF  = 255;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_COMMIT     = 3'd5,
    ST_HALT       = 3'd6,
    ST_ERROR      = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_BUS      = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } err_cause_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } dmem_req_t;

  function automatic logic is_timed(
    input seq_state_e s
  );
    return s inside {
      ST_FETCH_REQ, ST_FETCH_WAIT,
      ST_MEM_REQ, ST_MEM_WAIT
    };
  endfunction

endpackage

// File: rtl/core_seq_ctrl_mem_wait_timer.sv
// Cycle budget for memory handshake states;
// expired fires in the TIMEOUT-th enabled cycle.
module core_seq_ctrl_mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expired = enable &&
    (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: fetch, exec, optional
// data access, commit, around a 1-cycle IDU/EXU.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic [31:0] exu_dnpc,
  input  logic        exu_gpr_wen,
  input  logic        exu_mem_wen,
  input  logic        exu_mem_ren,
  input  logic [31:0] exu_mem_addr,
  input  logic [31:0] exu_mem_wdata,
  input  logic [7:0]  exu_mem_wmask,
  input  logic        exu_halt,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_wen,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [7:0]  dmem_req_wmask,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  input  logic        dmem_rsp_err,
  output logic        gpr_wen_o,
  output logic        wb_from_mem,
  output logic [31:0] load_data,
  output logic        commit,
  output logic        halted,
  output logic        err,
  output logic [1:0]  err_cause
);

  seq_state_e state;
  err_cause_e cause;
  dmem_req_t  mreq;
  logic       is_load;
  logic       dnpc_ok;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_exp;

  assign dnpc_ok = exu_dnpc[1:0] == 2'b00;

  // Quiet while reset is held, live at once after.
  assign imem_req_valid =
    rst_n && (state == ST_FETCH_REQ);
  assign imem_req_addr  = pc;

  assign dmem_req_valid = state == ST_MEM_REQ;
  assign dmem_req_wen   = mreq.wen;
  assign dmem_req_addr  = mreq.addr;
  assign dmem_req_wdata = mreq.wdata;
  assign dmem_req_wmask = mreq.wmask;

  assign commit      = state == ST_COMMIT;
  assign gpr_wen_o   = commit && exu_gpr_wen &&
                       dnpc_ok;
  assign wb_from_mem = commit && is_load;
  assign halted      = state == ST_HALT;
  assign err         = state == ST_ERROR;
  assign err_cause   = cause;

  // Every entry to a timed state follows either an
  // untimed state or a request handshake.
  assign tmr_en  = is_timed(state);
  assign tmr_clr = !tmr_en ||
    (imem_req_valid && imem_req_ready) ||
    (dmem_req_valid && dmem_req_ready);

  core_seq_ctrl_mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH_REQ;
      cause     <= CAUSE_NONE;
      pc        <= RESET_PC;
      inst      <= '0;
      load_data <= '0;
      mreq      <= '0;
      is_load   <= 1'b0;
    end else begin
      unique case (state)
        ST_FETCH_REQ: begin
          if (imem_req_ready) begin
            state <= ST_FETCH_WAIT;
          end else if (tmr_exp) begin
            state <= ST_ERROR;
            cause <= CAUSE_TIMEOUT;
          end
        end
        ST_FETCH_WAIT: begin
          if (imem_rsp_err) begin
            state <= ST_ERROR;
            cause <= CAUSE_BUS;
          end else if (imem_rsp_valid) begin
            inst  <= imem_rsp_data;
            state <= ST_EXEC;
          end else if (tmr_exp) begin
            state <= ST_ERROR;
            cause <= CAUSE_TIMEOUT;
          end
        end
        ST_EXEC: begin
          is_load <= exu_mem_ren;
          if (exu_mem_wen && exu_mem_ren) begin
            state <= ST_ERROR;
            cause <= CAUSE_TIMEOUT;
          end else if (exu_mem_wen ||
                       exu_mem_ren) begin
            mreq.wen   <= exu_mem_wen;
            mreq.addr  <= exu_mem_addr;
            mreq.wdata <= exu_mem_wdata;
            mreq.wmask <= exu_mem_wen ?
                          exu_mem_wmask : 8'h00;
            state      <= ST_MEM_REQ;
          end else begin
            state <= ST_COMMIT;
          end
        end
        ST_MEM_REQ: begin
          if (dmem_req_ready) begin
            state <= ST_MEM_WAIT;
          end else if (tmr_exp) begin
            state <= ST_ERROR;
            cause <= CAUSE_TIMEOUT;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_rsp_err) begin
            state <= ST_ERROR;
            cause <= CAUSE_BUS;
          end else if (dmem_rsp_valid) begin
            if (is_load) begin
              load_data <= dmem_rsp_data;
            end
            state <= ST_COMMIT;
          end else if (tmr_exp) begin
            state <= ST_ERROR;
            cause <= CAUSE_TIMEOUT;
          end
        end
        ST_COMMIT: begin
          if (!dnpc_ok) begin
            state <= ST_ERROR;
            cause <= CAUSE_MISALIGN;
          end else begin
            pc    <= exu_dnpc;
            state <= exu_halt ? ST_HALT :
                     ST_FETCH_REQ;
          end
        end
        ST_HALT:  state <= ST_HALT;
        ST_ERROR: state <= ST_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl with a
// rule-level model checked every cycle.
module tb_core_seq_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] exu_dnpc;
  logic        exu_gpr_wen;
  logic        exu_mem_wen;
  logic        exu_mem_ren;
  logic [31:0] exu_mem_addr;
  logic [31:0] exu_mem_wdata;
  logic [7:0]  exu_mem_wmask;
  logic        exu_halt;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_wen;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        dmem_rsp_err;
  logic        gpr_wen_o;
  logic        wb_from_mem;
  logic [31:0] load_data;
  logic        commit;
  logic        halted;
  logic        err;
  logic [1:0]  err_cause;

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .pc             (pc),
    .inst           (inst),
    .exu_dnpc       (exu_dnpc),
    .exu_gpr_wen    (exu_gpr_wen),
    .exu_mem_wen    (exu_mem_wen),
    .exu_mem_ren    (exu_mem_ren),
    .exu_mem_addr   (exu_mem_addr),
    .exu_mem_wdata  (exu_mem_wdata),
    .exu_mem_wmask  (exu_mem_wmask),
    .exu_halt       (exu_halt),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_wen   (dmem_req_wen),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_wmask (dmem_req_wmask),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .dmem_rsp_err   (dmem_rsp_err),
    .gpr_wen_o      (gpr_wen_o),
    .wb_from_mem    (wb_from_mem),
    .load_data      (load_data),
    .commit         (commit),
    .halted         (halted),
    .err            (err),
    .err_cause      (err_cause)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_rel = 0;
  int t_commit = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_load;
  logic        m_halted;
  logic        m_err;
  logic [1:0]  m_cause;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic        pv_i;
  logic [31:0] pa_i;
  logic        pv_d;
  logic [72:0] pf_d;
  logic        p_commit;

  // Per-cycle rule checks against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_i     <= 1'b0;
      pv_d     <= 1'b0;
      p_commit <= 1'b0;
    end else begin
      chk("pc", pc, m_pc);
      chk("inst", inst, m_inst);
      chk("load_data", load_data, m_load);
      chk1("halted", halted, m_halted);
      chk1("err", err, m_err);
      chk("err_cause", 32'(err_cause),
          32'(m_cause));
      chk1("gpr_wen_rule", gpr_wen_o,
           commit && exu_gpr_wen &&
           (exu_dnpc[1:0] == 2'b00));
      if (wb_from_mem)
        chk1("wb_needs_commit", commit, 1'b1);
      if (halted || err) begin
        chk1("quiet_imem", imem_req_valid, 1'b0);
        chk1("quiet_dmem", dmem_req_valid, 1'b0);
        chk1("quiet_commit", commit, 1'b0);
      end
      if (imem_req_valid)
        chk("imem_addr", imem_req_addr, m_pc);
      if (pv_i) begin
        chk1("imem_hold_v", imem_req_valid, 1'b1);
        chk("imem_hold_a", imem_req_addr, pa_i);
      end
      if (pv_d) begin
        chk1("dmem_hold_v", dmem_req_valid, 1'b1);
        chk("dmem_hold_a", dmem_req_addr,
            pf_d[72:41]);
        chk("dmem_hold_d", dmem_req_wdata,
            pf_d[40:9]);
        chk("dmem_hold_m",
            {23'd0, dmem_req_wen, dmem_req_wmask},
            {23'd0, pf_d[8:0]});
      end
      if (p_commit)
        chk1("commit_pulse", commit, 1'b0);
      pv_i <= imem_req_valid && !imem_req_ready;
      pa_i <= imem_req_addr;
      pv_d <= dmem_req_valid && !dmem_req_ready;
      pf_d <= {dmem_req_addr, dmem_req_wdata,
               dmem_req_wen, dmem_req_wmask};
      p_commit <= commit;
    end
  end

  task automatic model_reset();
    m_pc     = RPC;
    m_inst   = '0;
    m_load   = '0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_cause  = 2'd0;
  endtask

  task automatic set_exu(input logic [31:0] dn,
                         input logic gw,
                         input logic st,
                         input logic ld,
                         input logic hl,
                         input logic [31:0] ad,
                         input logic [31:0] wd,
                         input logic [7:0] wm);
    exu_dnpc      = dn;
    exu_gpr_wen   = gw;
    exu_mem_wen   = st;
    exu_mem_ren   = ld;
    exu_halt      = hl;
    exu_mem_addr  = ad;
    exu_mem_wdata = wd;
    exu_mem_wmask = wm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 0;
    dmem_req_ready = 0;
    dmem_rsp_valid = 0;
    dmem_rsp_data  = '0;
    dmem_rsp_err   = 0;
    set_exu(RPC + 4, 0, 0, 0, 0, '0, '0, '0);
    model_reset();
    step();
    step();
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_cause", 32'(err_cause), 32'd0);
    chk1("rst_ireq", imem_req_valid, 1'b0);
    chk1("rst_dreq", dmem_req_valid, 1'b0);
    chk1("rst_commit", commit, 1'b0);
    chk1("rst_gpr", gpr_wen_o, 1'b0);
    chk1("rst_halt", halted, 1'b0);
    chk1("rst_err", err, 1'b0);
    rst_n = 1'b1;
    t_rel = cyc;
    #1;
    chk1("first_req_v", imem_req_valid, 1'b1);
    chk("first_req_a", imem_req_addr, RPC);
  endtask

  task automatic fetch_only(input logic [31:0] i);
    int k = 0;
    while (!imem_req_valid && k < 20) begin
      step();
      k++;
    end
    chk1("fetch_req_seen", imem_req_valid, 1'b1);
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    imem_rsp_valid = 1;
    imem_rsp_data  = i;
    step();
    imem_rsp_valid = 0;
    m_inst = i;
  endtask

  task automatic do_inst(input logic [31:0] i,
                         input logic [31:0] dn,
                         input logic gw,
                         input logic st,
                         input logic ld,
                         input logic hl,
                         input logic [31:0] ad,
                         input logic [31:0] wd,
                         input logic [7:0] wm,
                         input logic [31:0] ldd,
                         input int stall);
    set_exu(dn, gw, st, ld, hl, ad, wd, wm);
    fetch_only(i);
    if (st || ld) begin
      step();
      chk1("dreq_v", dmem_req_valid, 1'b1);
      chk1("dreq_wen", dmem_req_wen, st);
      chk("dreq_addr", dmem_req_addr, ad);
      chk("dreq_mask", 32'(dmem_req_wmask),
          st ? 32'(wm) : 32'd0);
      if (st) chk("dreq_wdata", dmem_req_wdata, wd);
      for (int s = 0; s < stall; s++) begin
        step();
        chk1("stall_v", dmem_req_valid, 1'b1);
        chk("stall_a", dmem_req_addr, ad);
      end
      dmem_req_ready = 1;
      step();
      dmem_req_ready = 0;
      dmem_rsp_valid = 1;
      dmem_rsp_data  = ldd;
      step();
      dmem_rsp_valid = 0;
      if (ld) m_load = ldd;
    end else begin
      step();
    end
    t_commit = cyc;
    chk1("commit", commit, 1'b1);
    chk1("commit_gpr", gpr_wen_o,
         gw && (dn[1:0] == 2'b00));
    chk1("commit_wb", wb_from_mem, ld);
    step();
    if (dn[1:0] != 2'b00) begin
      m_err   = 1'b1;
      m_cause = 2'd2;
    end else begin
      m_pc = dn;
      if (hl) m_halted = 1'b1;
    end
  endtask

  task automatic fetch_timeout(input logic save);
    set_exu(RPC + 4, 1, 0, 0, 0, '0, '0, '0);
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    repeat (254) step();
    chk1("to_not_yet", err, 1'b0);
    if (!save) begin
      step();
      m_err   = 1'b1;
      m_cause = 2'd3;
      chk1("to_err", err, 1'b1);
      chk("to_cause", 32'(err_cause), 32'd3);
      repeat (3) step();
    end else begin
      imem_rsp_valid = 1;
      imem_rsp_data  = 32'h0010_0093;
      step();
      imem_rsp_valid = 0;
      m_inst = 32'h0010_0093;
      chk1("to_saved", err, 1'b0);
      step();
      chk1("to_saved_commit", commit, 1'b1);
      step();
      m_pc = RPC + 4;
      chk("to_saved_pc", pc, 32'h8000_0004);
    end
  endtask

  initial begin
    do_reset();
    do_inst(32'h0010_0093, RPC + 4, 1, 0, 0, 0,
            '0, '0, '0, '0, 0);
    chk("lat_alu", t_commit - t_rel + 1, 4);
    chk("pc_after_addi", pc, 32'h8000_0004);

    do_inst(32'h00b5_2023, RPC + 8, 0, 1, 0, 0,
            32'h8000_1000, 32'h1234_5678, 8'h0F,
            32'h5555_AAAA, 3);
    chk("store_keeps_load", load_data, 32'd0);

    do_inst(32'h0005_2503, RPC + 12, 1, 0, 1, 0,
            32'h8000_2000, '0, 8'hFF,
            32'hDEAD_BEEF, 0);
    chk("load_val", load_data, 32'hDEAD_BEEF);

    do_inst(32'h0010_0073, RPC + 16, 0, 0, 0, 1,
            '0, '0, '0, '0, 0);
    imem_req_ready = 1;
    repeat (5) step();
    imem_req_ready = 0;
    chk1("halted", halted, 1'b1);
    chk("halt_pc", pc, 32'h8000_0010);

    do_reset();
    do_inst(32'h0000_8067, 32'h8000_0002, 1,
            0, 0, 0, '0, '0, '0, '0, 0);
    chk1("jalr_err", err, 1'b1);
    chk("jalr_cause", 32'(err_cause), 32'd2);
    imem_req_ready = 1;
    repeat (5) step();
    imem_req_ready = 0;

    do_reset();
    fetch_timeout(1'b0);
    do_reset();
    fetch_timeout(1'b1);

    do_reset();
    set_exu(RPC + 4, 0, 1, 1, 0, '0, '0, 8'hF);
    fetch_only(32'h1234_0003);
    step();
    m_err   = 1'b1;
    m_cause = 2'd3;
    chk("ldst_cause", 32'(err_cause), 32'd3);
    chk1("ldst_no_dreq", dmem_req_valid, 1'b0);

    do_reset();
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    imem_rsp_valid = 1;
    imem_rsp_err   = 1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    step();
    imem_rsp_valid = 0;
    imem_rsp_err   = 0;
    m_err   = 1'b1;
    m_cause = 2'd1;
    chk("bus_cause", 32'(err_cause), 32'd1);
    repeat (2) step();

    do_reset();
    do_inst(32'h0010_0093, RPC + 4, 1, 0, 0, 0,
            '0, '0, '0, '0, 0);
    set_exu(RPC + 8, 1, 0, 1, 0,
            32'h8000_3000, '0, '0);
    fetch_only(32'h0005_2503);
    step();
    dmem_req_ready = 1;
    step();
    dmem_req_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, RPC);
    chk("arst_inst", inst, 32'd0);
    chk1("arst_dreq", dmem_req_valid, 1'b0);
    chk1("arst_ireq", imem_req_valid, 1'b0);
    chk1("arst_commit", commit, 1'b0);
    model_reset();
    dmem_rsp_valid = 1;
    dmem_rsp_data  = 32'hBAD0_BAD0;
    step();
    step();
    rst_n = 1'b1;
    step();
    dmem_rsp_valid = 0;
    chk("late_rsp_ignored", load_data, 32'd0);
    do_inst(32'h0010_0093, RPC + 4, 1, 0, 0, 0,
            '0, '0, '0, '0, 0);
    chk("post_rst_pc", pc, 32'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

endmodule
